// File: rtl/seg7_pkg.sv
// Shared glyph codes and active-low segment patterns for the 7-segment scan multiplexer.
package seg7_pkg;

    localparam logic [3:0] GLYPH_P     = 4'd0;
    localparam logic [3:0] GLYPH_L     = 4'd1;
    localparam logic [3:0] GLYPH_A     = 4'd2;
    localparam logic [3:0] GLYPH_Y     = 4'd3;
    localparam logic [3:0] GLYPH_U     = 4'd4;
    localparam logic [3:0] GLYPH_S     = 4'd5;
    localparam logic [3:0] GLYPH_E     = 4'd6;
    localparam logic [3:0] GLYPH_H     = 4'd7;
    localparam logic [3:0] GLYPH_O     = 4'd8;
    localparam logic [3:0] GLYPH_BLANK = 4'hF;

    // Segment order {a,b,c,d,e,f,g}, a in bit 6, 0 = lit.
    localparam logic [6:0] SEG_P     = 7'b0011000;
    localparam logic [6:0] SEG_L     = 7'b1110001;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_Y     = 7'b1000100;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_S     = 7'b0100100;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_H     = 7'b1001000;
    localparam logic [6:0] SEG_O     = 7'b0000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_glyph_dec.sv
// Combinational 4-bit glyph code to active-low 7-segment pattern decoder.
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            GLYPH_P:     seg = SEG_P;
            GLYPH_L:     seg = SEG_L;
            GLYPH_A:     seg = SEG_A;
            GLYPH_Y:     seg = SEG_Y;
            GLYPH_U:     seg = SEG_U;
            GLYPH_S:     seg = SEG_S;
            GLYPH_E:     seg = SEG_E;
            GLYPH_H:     seg = SEG_H;
            GLYPH_O:     seg = SEG_O;
            GLYPH_BLANK: seg = SEG_BLANK;
            default:     seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver with frame-synchronous code update.
// Optional blink support is built when SEG7_BLINK_EN is defined.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] codes_i,
    input  logic                    update_i,
    input  logic [NUM_DIGITS-1:0]   blank_i,
    input  logic [NUM_DIGITS-1:0]   blink_i,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic [6:0]              DISPLAY,
    output logic                    frame_o
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                presc;
    logic [IW-1:0]                idx, idx_n;
    logic [NUM_DIGITS-1:0][3:0]   shadow, active, active_n;
    logic                         pending, tick, boundary;
    logic                         blink_hit, blanked;
    logic [3:0]                   sel_code;
    logic [6:0]                   sel_seg;

    assign tick     = (presc == PRE_LAST);
    assign boundary = tick && (idx == IDX_LAST);
    assign idx_n    = (idx == IDX_LAST) ? '0 : idx + IW'(1);

    // Codes only swap at the frame boundary; a strobe on that same edge bypasses the shadow.
    always_comb begin
        active_n = active;
        if (boundary && update_i)
            active_n = codes_i;
        else if (boundary && pending)
            active_n = shadow;
    end

    // Outputs are registered from the next index so anode and segments move together.
    assign sel_code = active_n[idx_n];

    seg7_glyph_dec u_dec (
        .code (sel_code),
        .seg  (sel_seg)
    );

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] bcnt;
    logic          phase, phase_n;

    assign phase_n = (boundary && bcnt == BLINK_LAST) ? ~phase : phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (boundary) begin
            bcnt  <= (bcnt == BLINK_LAST) ? '0 : bcnt + BW'(1);
            phase <= phase_n;
        end
    end

    assign blink_hit = phase_n & blink_i[idx_n];
`else
    // Blink disabled: the mask is read but always gated off (BLINK_FRAMES >= 1).
    assign blink_hit = blink_i[idx_n] & (BLINK_FRAMES < 1);
`endif

    assign blanked = blank_i[idx_n] | blink_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            idx     <= '0;
            pending <= 1'b0;
            shadow  <= {NUM_DIGITS{GLYPH_BLANK}};
            active  <= {NUM_DIGITS{GLYPH_BLANK}};
            DIGIT   <= '1;
            DISPLAY <= SEG_BLANK;
            frame_o <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + PW'(1);
            frame_o <= boundary;
            active  <= active_n;
            if (update_i)
                shadow <= codes_i;
            if (boundary)
                pending <= 1'b0;
            else if (update_i)
                pending <= 1'b1;
            if (tick) begin
                idx     <= idx_n;
                DIGIT   <= ~(NUM_DIGITS'(1) << idx_n);
                DISPLAY <= blanked ? SEG_BLANK : sel_seg;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Self-checking bench for seg7_scan_mux: directed scenarios, glyph table and random run vs a frame-level model.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BF = 2;
`ifdef SEG7_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] codes = '0;
    logic        update = 1'b0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        frame_o;

    seg7_scan_mux #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk      (clk),
        .rst      (rst),
        .codes_i  (codes),
        .update_i (update),
        .blank_i  (blank),
        .blink_i  (blink),
        .DIGIT    (DIGIT),
        .DISPLAY  (DISPLAY),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Frame-level reference: edges since reset, latest strobed codes, codes latched per frame.
    int          n;
    int          fcnt;
    logic [15:0] latest, fcodes;
    logic [3:0]  e_dig;
    logic [6:0]  e_disp;
    logic        e_frm;

    typedef struct {
        logic [3:0] code;
        logic [6:0] seg;
    } vec_t;
    vec_t tbl[16];

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'd0: return 7'b0011000;
            4'd1: return 7'b1110001;
            4'd2: return 7'b0001000;
            4'd3: return 7'b1000100;
            4'd4: return 7'b1000001;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0110000;
            4'd7: return 7'b1001000;
            4'd8: return 7'b0000001;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_edge();
        int slot;
        if (rst) begin
            n = 0; fcnt = 0; latest = '1; fcodes = '1;
            e_dig = '1; e_disp = '1; e_frm = 1'b0;
            return;
        end
        n++;
        e_frm = 1'b0;
        if (update) latest = codes;
        if (n % SD == 0) begin
            slot = (n / SD) % ND;
            if (slot == 0) begin
                fcnt++;
                fcodes = latest;
                e_frm = 1'b1;
            end
            e_dig  = ~(4'b0001 << slot);
            e_disp = glyph(fcodes[slot*4 +: 4]);
            if (blank[slot] || (BLINK_ON && blink[slot] && ((fcnt / BF) % 2 == 1)))
                e_disp = 7'b1111111;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock: model follows the edge, DUT compared against it on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        checks++;
        if ({DIGIT, DISPLAY, frame_o} !== {e_dig, e_disp, e_frm}) begin
            errors++;
            $display("FAIL model n=%0d: got DIGIT=%b DISPLAY=%b frame=%b expected %b %b %b",
                     n, DIGIT, DISPLAY, frame_o, e_dig, e_disp, e_frm);
        end
    endtask

    task automatic wait_frame();
        int k;
        cycle();
        for (k = 0; k < 64 && frame_o !== 1'b1; k++) cycle();
        if (frame_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: got no frame_o expected pulse within 64 cycles");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        logic [3:0]  exp_dig[4];
        logic [6:0]  exp_seg[4];
        for (int i = 0; i < 16; i++) begin
            tbl[i].code = 4'(i);
            tbl[i].seg  = (i > 8) ? 7'b1111111 : 7'b0;
        end
        tbl[0].seg = 7'b0011000; tbl[1].seg = 7'b1110001; tbl[2].seg = 7'b0001000;
        tbl[3].seg = 7'b1000100; tbl[4].seg = 7'b1000001; tbl[5].seg = 7'b0100100;
        tbl[6].seg = 7'b0110000; tbl[7].seg = 7'b1001000; tbl[8].seg = 7'b0000001;
        exp_dig[0] = 4'b1110; exp_dig[1] = 4'b1101; exp_dig[2] = 4'b1011; exp_dig[3] = 4'b0111;
        exp_seg[0] = 7'b0011000; exp_seg[1] = 7'b1110001;
        exp_seg[2] = 7'b0001000; exp_seg[3] = 7'b1000100;

        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        chk("reset_digit", DIGIT, 4'b1111);
        chk("reset_display", DISPLAY, 7'b1111111);
        chk("reset_frame", frame_o, 1'b0);
        rst = 1'b0;

        // Scenario 1: P L A Y across the four slots, 4 cycles each
        codes = 16'h3210; update = 1'b1;
        cycle();
        update = 1'b0;
        wait_frame();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                chk("s1_digit", DIGIT, exp_dig[s]);
                chk("s1_display", DISPLAY, exp_seg[s]);
                cycle();
            end
        end

        // Scenario 2: mid-frame update must not tear the current frame
        cycle();
        codes = 16'h8888; update = 1'b1;
        cycle();
        update = 1'b0; codes = 16'h1111;
        for (k = 0; k < 40; k++) begin
            cycle();
            if (frame_o === 1'b1) break;
            chk("s2_no_tear", DISPLAY == 7'b0000001, 1'b0);
        end
        chk("s2_frame", frame_o, 1'b1);
        chk("s2_digit", DIGIT, 4'b1110);
        chk("s2_display", DISPLAY, 7'b0000001);

        // Scenario 3: strobe on the boundary tick goes straight to slot 0
        repeat (15) cycle();
        codes = 16'h5555; update = 1'b1;
        cycle();
        update = 1'b0;
        chk("s3_frame", frame_o, 1'b1);
        chk("s3_digit", DIGIT, 4'b1110);
        chk("s3_display", DISPLAY, 7'b0100100);

        // Scenario 4: forced blank on digit 2 still selects the anode
        codes = 16'h5255; update = 1'b1;
        cycle();
        update = 1'b0;
        wait_frame();
        blank = 4'b0100;
        repeat (4) cycle();
        chk("s4_slot1_digit", DIGIT, 4'b1101);
        chk("s4_slot1_display", DISPLAY, 7'b0100100);
        repeat (4) cycle();
        chk("s4_digit", DIGIT, 4'b1011);
        chk("s4_display", DISPLAY, 7'b1111111);
        blank = 4'b0000;
        cycle();

        // Scenario 6: reset during slot 2, then restart timing
        rst = 1'b1;
        cycle();
        chk("s6_digit", DIGIT, 4'b1111);
        chk("s6_display", DISPLAY, 7'b1111111);
        chk("s6_frame", frame_o, 1'b0);
        rst = 1'b0;
        repeat (3) cycle();
        chk("s6_pre_tick_digit", DIGIT, 4'b1111);
        cycle();
        chk("s6_first_tick_digit", DIGIT, 4'b1101);
        for (k = 0; k < 64; k++) begin
            cycle();
            if (frame_o === 1'b1) break;
        end
        chk("s6_first_frame_dist", 16'(k), 16'd11);

        // Glyph table: every code shown on slot 0
        for (int i = 0; i < 16; i++) begin
            codes = {4{tbl[i].code}}; update = 1'b1;
            cycle();
            update = 1'b0;
            wait_frame();
            chk("glyph_display", DISPLAY, tbl[i].seg);
        end

`ifdef SEG7_BLINK_EN
        // Scenario 5: digit 0 alternates visible/blank every BF frames
        blink = 4'b0001; codes = 16'h0000; update = 1'b1;
        cycle();
        update = 1'b0;
        for (int f = 0; f < 8; f++) begin
            wait_frame();
            chk("s5_blink", DISPLAY, ((fcnt / BF) % 2 == 1) ? 7'b1111111 : 7'b0011000);
        end
        blink = 4'b0000;
`endif

        // Random run against the model
        for (int r = 0; r < 1500; r++) begin
            rst    = ($urandom % 300 == 0);
            update = ($urandom % 8 == 0);
            codes  = 16'($urandom);
            if ($urandom % 16 == 0) blank = 4'($urandom & $urandom);
            blink  = 4'($urandom);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal minimum 1.
REQ-003 Parameter BLINK_FRAMES, default 64, full frames per blink half-period; legal minimum 1.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 codes_i  in  4*NUM_DIGITS  glyph code per digit; digit k occupies bits [4k+3:4k].
REQ-007 update_i  in  1  one-cycle strobe that captures codes_i into the shadow register.
REQ-008 blank_i  in  NUM_DIGITS  per-digit force-blank mask.
REQ-009 blink_i  in  NUM_DIGITS  per-digit blink enable mask.
REQ-010 DIGIT  out  NUM_DIGITS  active-low one-hot anode select, registered.
REQ-011 DISPLAY  out  7  active-low segments {a,b,c,d,e,f,g}, a in bit 6, registered.
REQ-012 frame_o  out  1  one-cycle pulse when slot 0 is entered.

Function
REQ-013 Prescaler counts 0..SCAN_DIV-1; tick asserts on the cycle it equals SCAN_DIV-1, then wraps to 0.
REQ-014 On tick, digit index advances by 1 and wraps from NUM_DIGITS-1 to 0.
REQ-015 On the cycle after a tick, DIGIT and DISPLAY both reflect the new index, with zero skew between anode and segments.
REQ-016 Glyph map: 0=P, 1=L, 2=A, 3=Y, 4=U, 5=S, 6=E, 7=H, 8=O; codes 9..15 decode to blank (7'b1111111).
REQ-017 Segment patterns, active-low: P=0011000, L=1110001, A=0001000, Y=1000100, U=1000001, S=0100100, E=0110000, H=1001000, O=0000001.
REQ-018 A digit whose blank_i bit is set drives DISPLAY=7'b1111111; DIGIT still selects it.
REQ-019 update_i set -> shadow <= codes_i and pending <= 1; a later strobe before the frame boundary overwrites shadow.
REQ-020 Frame boundary is the tick that wraps the index to 0; at the boundary, if pending, active <= shadow and pending <= 0.
REQ-021 If update_i and the frame boundary coincide, active <= codes_i directly and pending <= 0.
REQ-022 Displayed codes change only at frame boundaries, so no mid-frame tearing occurs.
REQ-023 frame_o is high exactly on the cycle DIGIT first shows slot 0.
REQ-024 With SCAN_DIV=1, a tick occurs every cycle and the index advances every cycle.
REQ-025 With NUM_DIGITS=1, DIGIT is constant 1'b0 after the first tick and frame_o pulses every tick.

Reset
REQ-026 rst resets: prescaler=0, index=0, pending=0, shadow=active=all 4'hF, blink counter=0, blink phase=0.
REQ-027 rst resets outputs: DIGIT all ones, DISPLAY=7'b1111111, frame_o=0.
REQ-028 rst mid-scan takes effect on the next edge; the first tick after reset selects index 1; the first frame_o arrives after NUM_DIGITS ticks.

Configuration
REQ-029 Macro SEG7_BLINK_EN defined: a frame counter toggles the blink phase every BLINK_FRAMES frame boundaries; when phase=1, digits with blink_i set display blank.
REQ-030 Macro SEG7_BLINK_EN absent: the blink_i port remains present but is ignored, and no blink counter is built.

Structure
REQ-031 Package seg7_pkg holds the glyph code localparams (GLYPH_P..GLYPH_O, GLYPH_BLANK=4'hF) and the 7-bit segment pattern constants.
REQ-032 Combinational sub-module seg7_glyph_dec (4-bit code -> 7-bit pattern) is instantiated once on the selected code.

Verification
REQ-033 Bench parameters for all scenarios: NUM_DIGITS=4, SCAN_DIV=4.
REQ-034 Scenario 1: rst, then codes=0x3210, update -> after the next boundary, successive slots show DIGIT 1110/1101/1011/0111 with DISPLAY P/L/A/Y, each slot held 4 cycles.
REQ-035 Scenario 2: update mid-frame with 0x8888 -> the current frame is unchanged, and O appears only from the slot-0 cycle where frame_o=1.
REQ-036 Scenario 3: update asserted on the boundary tick with 0x5555 -> slot 0 shows S in that same frame.
REQ-037 Scenario 4: blank_i=4'b0100 with code A on digit 2 -> DIGIT=1011, DISPLAY=1111111.
REQ-038 Scenario 5: with SEG7_BLINK_EN, BLINK_FRAMES=2, blink_i=4'b0001 -> digit 0 alternates visible and blank every 2 frames.
REQ-039 Scenario 6: rst asserted during slot 2 -> next cycle DIGIT=1111, DISPLAY=1111111, frame_o=0.
